// File: rtl/lfsr_checker.sv
// Receive-side checker for the 33-bit XNOR LFSR stream (taps 32/19): self-synchronises,
// declares lock after a run of correct predictions, and counts bit errors while locked.
module lfsr_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_errs,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck
);

  // state    | meaning
  // S_FILL   | loading the first 33 bits into the history, no comparisons
  // S_VERIFY | predicting, counting consecutive matches toward lock
  // S_LOCKED | stream verified, mispredictions are counted as errors
  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam int MW = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT)  : 1;
  localparam int BW = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LAST   = BW'(UNLOCK_ERRS - 1);
  localparam logic [5:0]    FILL_LAST  = 6'd32;

  logic [1:0]       state;
  logic [32:0]      hist;
  logic [5:0]       fill_cnt;
  logic [MW-1:0]    match_cnt;
  logic [BW-1:0]    bad_cnt;
  logic             pred;
  logic             mis;
  logic             all_ones;
  logic             count_err;
  logic [ERR_W-1:0] err_next;

  assign pred      = hist[32] ~^ hist[19];
  assign mis       = bit_in != pred;
  assign all_ones  = &{hist[31:0], bit_in};
  // An all-ones window is the XNOR lock-up pattern and is never treated as an error.
  assign count_err = bit_valid && (state == S_LOCKED) && mis && !all_ones;
  assign locked    = (state == S_LOCKED);

  // Clear first, then count, so a simultaneous clear and error leaves a count of one.
  always_comb begin
    err_next = err_count;
    if (clear_errs) err_next = '0;
    if (count_err && (err_next != {ERR_W{1'b1}})) err_next = err_next + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      bit_err   <= 1'b0;
      err_count <= '0;
      stuck     <= 1'b0;
    end else begin
      err_count <= err_next;
      bit_err   <= count_err;
      if (bit_valid) begin
        hist <= {hist[31:0], bit_in};
        case (state)
          S_FILL: begin
            fill_cnt <= fill_cnt + 6'd1;
            if (fill_cnt == FILL_LAST) state <= S_VERIFY;
          end
          S_VERIFY: begin
            stuck <= all_ones;
            if (all_ones || mis) begin
              match_cnt <= '0;
            end else if (match_cnt == MATCH_LAST) begin
              match_cnt <= '0;
              state     <= S_LOCKED;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          S_LOCKED: begin
            stuck <= all_ones;
            if (all_ones) begin
              state     <= S_VERIFY;
              match_cnt <= '0;
              bad_cnt   <= '0;
            end else if (mis) begin
              if (bad_cnt == BAD_LAST) begin
                state     <= S_VERIFY;
                match_cnt <= '0;
                bad_cnt   <= '0;
              end else begin
                bad_cnt <= bad_cnt + 1'b1;
              end
            end else begin
              bad_cnt <= '0;
            end
          end
          default: state <= S_FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a reference generator drives the stream and each valid
// bit pushes its expected locked/bit_err/stuck result, popped and compared after the edge.
module tb_lfsr_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clear_errs = 1'b0;
  logic        locked, bit_err, stuck;
  logic [15:0] err_count;
  logic        locked4, bit_err4, stuck4;
  logic [3:0]  err_count4;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .clear_errs(clear_errs), .locked(locked), .bit_err(bit_err),
    .err_count(err_count), .stuck(stuck)
  );

  lfsr_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .clear_errs(clear_errs), .locked(locked4), .bit_err(bit_err4),
    .err_count(err_count4), .stuck(stuck4)
  );

  typedef struct packed {logic lk; logic er; logic st;} exp_t;
  exp_t sb[$];
  int tests_run = 0;
  int failed = 0;
  logic [32:0] gen;  // reference generator state
  logic [32:0] tx;   // last 33 bits actually sent

  task automatic next_gen(output logic b);
    b = gen[32] ~^ gen[19];
    gen = {gen[31:0], b};
  endtask

  // Inverse of what the received history predicts: guaranteed misprediction.
  task automatic bad_bit(output logic b);
    b = ~(tx[32] ~^ tx[19]);
  endtask

  task automatic send(input logic b, input logic e_lk, input logic e_er, input logic e_st);
    exp_t ex;
    bit_valid = 1'b1;
    bit_in = b;
    tx = {tx[31:0], b};
    sb.push_back({e_lk, e_er, e_st});
    @(posedge clk); #1;
    bit_valid = 1'b0;
    clear_errs = 1'b0;
    ex = sb.pop_front();
    tests_run++;
    if (locked !== ex.lk) begin
      failed++;
      $display("FAIL locked t=%0t: got %b want %b", $time, locked, ex.lk);
    end
    tests_run++;
    if (bit_err !== ex.er) begin
      failed++;
      $display("FAIL bit_err t=%0t: got %b want %b", $time, bit_err, ex.er);
    end
    tests_run++;
    if (stuck !== ex.st) begin
      failed++;
      $display("FAIL stuck t=%0t: got %b want %b", $time, stuck, ex.st);
    end
  endtask

  task automatic pulse_clear();
    clear_errs = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk); #1;
    clear_errs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bit_valid = 1'b0;
    clear_errs = 1'b0;
    #1;
    tests_run++;
    if ({locked, bit_err, stuck, err_count} !== 19'd0 || {locked4, bit_err4, stuck4, err_count4} !== 7'd0) begin
      failed++;
      $display("FAIL reset_outputs: got %b%b%b %h / %b%b%b %h want all zero",
               locked, bit_err, stuck, err_count, locked4, bit_err4, stuck4, err_count4);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    gen = '0;
    tx = '0;
    sb.delete();
  endtask

  task automatic test_lock_acquire();
    logic b;
    for (int n = 1; n <= 49; n++) begin
      next_gen(b);
      send(b, n >= 49, 1'b0, 1'b0);
    end
    tests_run++;
    if (err_count !== 16'd0) begin
      failed++;
      $display("FAIL lock_err_count: got %0d want 0", err_count);
    end
  endtask

  task automatic test_single_flip();
    logic b;
    pulse_clear();
    for (int i = 0; i < 60; i++) begin
      next_gen(b);
      send(b ^ (i == 5), 1'b1, (i == 5) || (i == 25) || (i == 38), 1'b0);
    end
    tests_run++;
    if (err_count !== 16'd3) begin
      failed++;
      $display("FAIL flip_err_count: got %0d want 3", err_count);
    end
  endtask

  task automatic test_unlock_relock();
    logic b;
    pulse_clear();
    for (int i = 0; i < 8; i++) begin
      bad_bit(b);
      send(b, i < 7, 1'b1, 1'b0);
    end
    tests_run++;
    if (err_count !== 16'd8) begin
      failed++;
      $display("FAIL unlock_err_count: got %0d want 8", err_count);
    end
    gen = tx;
    for (int i = 0; i < 16; i++) begin
      next_gen(b);
      send(b, i == 15, 1'b0, 1'b0);
    end
  endtask

  task automatic test_stuck();
    logic b;
    test_reset();
    for (int n = 1; n <= 73; n++) send(1'b1, 1'b0, 1'b0, n >= 34);
    tests_run++;
    if (err_count !== 16'd0) begin
      failed++;
      $display("FAIL stuck_fill_err_count: got %0d want 0", err_count);
    end
    // Zero-seed stream: bits 74..80 are ones, so an all-ones run from 81 fills the window at 106.
    test_reset();
    for (int n = 1; n <= 80; n++) begin
      next_gen(b);
      send(b, n >= 49, 1'b0, 1'b0);
    end
    for (int m = 81; m <= 113; m++)
      send(1'b1, m < 106, (m >= 81 && m <= 86) || (m >= 100 && m <= 105), m >= 106);
    tests_run++;
    if (err_count !== 16'd12) begin
      failed++;
      $display("FAIL stuck_locked_err_count: got %0d want 12", err_count);
    end
  endtask

  task automatic test_random_valid();
    logic b;
    int n;
    test_reset();
    n = 0;
    for (int c = 0; c < 2000 && n < 60; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        n++;
        next_gen(b);
        send(b, n >= 49, 1'b0, 1'b0);
      end else begin
        bit_valid = 1'b0;
        bit_in = $urandom_range(1, 0) == 1;
        @(posedge clk); #1;
        tests_run++;
        if (bit_err !== 1'b0 || locked !== (n >= 49)) begin
          failed++;
          $display("FAIL idle_cycle: got err=%b locked=%b want err=0 locked=%b", bit_err, locked, n >= 49);
        end
      end
    end
    tests_run++;
    if (n != 60 || err_count !== 16'd0) begin
      failed++;
      $display("FAIL random_valid_done: got bits=%0d errs=%0d want 60 and 0", n, err_count);
    end
  endtask

  task automatic test_saturate_and_reset();
    logic b;
    test_reset();
    for (int n = 1; n <= 49; n++) begin
      next_gen(b);
      send(b, n >= 49, 1'b0, 1'b0);
    end
    pulse_clear();
    for (int k = 0; k < 20; k++) begin
      bad_bit(b);
      send(b, 1'b1, 1'b1, 1'b0);
      gen = tx;
      for (int j = 0; j < 2; j++) begin
        next_gen(b);
        send(b, 1'b1, 1'b0, 1'b0);
      end
    end
    tests_run++;
    if (err_count4 !== 4'd15 || err_count !== 16'd20 || locked4 !== 1'b1) begin
      failed++;
      $display("FAIL saturate: got w4=%0d w16=%0d lock4=%b want 15 20 1", err_count4, err_count, locked4);
    end
    clear_errs = 1'b1;
    bad_bit(b);
    send(b, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (err_count !== 16'd1 || err_count4 !== 4'd1) begin
      failed++;
      $display("FAIL clear_with_error: got %0d/%0d want 1/1", err_count, err_count4);
    end
    gen = tx;
    next_gen(b);
    bit_valid = 1'b1;
    bit_in = b;
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({locked, bit_err, stuck, err_count} !== 19'd0 || {locked4, bit_err4, err_count4} !== 6'd0) begin
      failed++;
      $display("FAIL async_reset: got %b%b%b %h / %b%b %h want all zero",
               locked, bit_err, stuck, err_count, locked4, bit_err4, err_count4);
    end
    bit_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    gen = '0;
    tx = '0;
    for (int n = 1; n <= 49; n++) begin
      next_gen(b);
      send(b, n >= 49, 1'b0, 1'b0);
    end
  endtask

  initial begin
    gen = '0;
    tx = '0;
    test_reset();
    test_lock_acquire();
    test_single_flip();
    test_unlock_relock();
    test_stuck();
    test_random_valid();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
